// File: rtl/minimax_dbus_ctrl_if.sv
// minimax_dbus_ctrl_if: core, host, RAM, console and status signals of the data-bus controller
interface minimax_dbus_ctrl_if #(parameter int ADDR_BITS = 12);
   logic [31:0]          addr;
   logic [31:0]          wdata;
   logic [3:0]           wmask;
   logic                 rreq;
   logic [31:0]          rdata;
   logic                 rack;
   logic                 host_req;
   logic                 host_we;
   logic [ADDR_BITS-1:0] host_addr;
   logic [31:0]          host_wdata;
   logic [3:0]           host_wmask;
   logic                 host_gnt;
   logic                 host_rvalid;
   logic [31:0]          host_rdata;
   logic                 ram_en;
   logic [3:0]           ram_we;
   logic [ADDR_BITS-3:0] ram_addr;
   logic [31:0]          ram_wdata;
   logic [31:0]          ram_rdata;
   logic                 con_valid;
   logic [31:0]          con_data;
   logic                 con_ready;
   logic                 halted;
   logic                 overflow;
   logic                 bus_err;
   modport slave (
      input  addr, wdata, wmask, rreq, host_req, host_we, host_addr, host_wdata, host_wmask,
             ram_rdata, con_ready,
      output rdata, rack, host_gnt, host_rvalid, host_rdata, ram_en, ram_we, ram_addr, ram_wdata,
             con_valid, con_data, halted, overflow, bus_err
   );
   modport master (
      output addr, wdata, wmask, rreq, host_req, host_we, host_addr, host_wdata, host_wmask,
             ram_rdata, con_ready,
      input  rdata, rack, host_gnt, host_rvalid, host_rdata, ram_en, ram_we, ram_addr, ram_wdata,
             con_valid, con_data, halted, overflow, bus_err
   );
endinterface

// File: rtl/minimax_dbus_ctrl.sv
// minimax_dbus_ctrl: core/host arbitration onto one pipelined RAM, console FIFO and halt MMIO
module minimax_dbus_ctrl #(
   parameter int          ADDR_BITS    = 12,
   parameter int          RAM_LATENCY  = 1,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] CONSOLE_ADDR = 32'hfffffff8,
   parameter logic [31:0] HALT_ADDR    = 32'hfffffffc
) (
   input logic             clk,
   input logic             reset,
   minimax_dbus_ctrl_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef struct packed {
      logic        core;
      logic        host;
      logic        mmio;
      logic [31:0] data;
   } rd_t;
   rd_t           pipe_q [RAM_LATENCY];
   rd_t           pipe_d [RAM_LATENCY];
   logic [31:0]   fifo_q [FIFO_DEPTH];
   logic [31:0]   fifo_d [FIFO_DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          halted_q, halted_d, overflow_q, overflow_d, bus_err_q, bus_err_d;
   logic          in_ram, is_con, is_halt, unmapped, core_wr, full_wr, core_ram_wr, core_ram_rd;
   logic          core_ram_access, gnt, host_rd, full, empty, pop, push_req, push;
   logic [31:0]   mmio_rdata;
   rd_t           tail;
   always_comb begin
      in_ram          = bus.addr[31:ADDR_BITS] == '0;
      is_con          = bus.addr == CONSOLE_ADDR;
      is_halt         = bus.addr == HALT_ADDR;
      unmapped        = ~(in_ram | is_con | is_halt);
      core_wr         = (|bus.wmask) & ~halted_q & ~reset;
      full_wr         = core_wr & (bus.wmask == 4'hf);
      core_ram_wr     = core_wr & in_ram;
      core_ram_rd     = bus.rreq & in_ram & ~reset;
      core_ram_access = core_ram_wr | core_ram_rd;
      gnt             = bus.host_req & ~core_ram_access & ~reset;
      host_rd         = gnt & ~bus.host_we;
      empty           = cnt_q == '0;
      full            = cnt_q == (PW+1)'(FIFO_DEPTH);
      pop             = ~empty & bus.con_ready & ~reset;
      push_req        = full_wr & is_con;
      push            = push_req & (~full | pop);
      mmio_rdata      = is_con ? {30'b0, full, ~empty} : is_halt ? {31'b0, halted_q} : 32'b0;
      tail            = pipe_q[RAM_LATENCY-1];
   end
   assign bus.host_gnt    = gnt;
   assign bus.ram_en      = core_ram_access | gnt;
   assign bus.ram_we      = core_ram_wr ? bus.wmask : (gnt & bus.host_we) ? bus.host_wmask : 4'b0;
   assign bus.ram_addr    = core_ram_access ? bus.addr[ADDR_BITS-1:2] :
                            gnt ? bus.host_addr[ADDR_BITS-1:2] : '0;
   assign bus.ram_wdata   = core_ram_wr ? bus.wdata : gnt ? bus.host_wdata : '0;
   // Reset gates the return stage so an in-flight read never acknowledges
   assign bus.rack        = tail.core & ~reset;
   assign bus.rdata       = bus.rack ? (tail.mmio ? tail.data : bus.ram_rdata) : '0;
   assign bus.host_rvalid = tail.host & ~reset;
   assign bus.host_rdata  = bus.host_rvalid ? bus.ram_rdata : '0;
   assign bus.con_valid   = ~empty & ~reset;
   assign bus.con_data    = bus.con_valid ? fifo_q[rp_q] : '0;
   assign bus.halted      = halted_q;
   assign bus.overflow    = overflow_q;
   assign bus.bus_err     = bus_err_q;
   always_comb begin
      pipe_d[0] = {bus.rreq & ~reset, host_rd, ~in_ram, mmio_rdata};
      for (int i = 1; i < RAM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      fifo_d = fifo_q;
      fifo_d[wp_q] = push ? bus.wdata : fifo_q[wp_q];
      wp_d       = wp_q + PW'(push);
      rp_d       = rp_q + PW'(pop);
      cnt_d      = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      halted_d   = halted_q | (full_wr & is_halt);
      overflow_d = overflow_q | (push_req & ~push);
      bus_err_d  = bus_err_q | (unmapped & (bus.rreq | core_wr));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_q     <= '{default: '0};
         fifo_q     <= '{default: '0};
         wp_q       <= '0;
         rp_q       <= '0;
         cnt_q      <= '0;
         halted_q   <= 1'b0;
         overflow_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         pipe_q     <= pipe_d;
         fifo_q     <= fifo_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         cnt_q      <= cnt_d;
         halted_q   <= halted_d;
         overflow_q <= overflow_d;
         bus_err_q  <= bus_err_d;
      end
   end
endmodule

// File: tb/tb_minimax_dbus_ctrl.sv
// tb_minimax_dbus_ctrl: directed checks of arbitration, read return, console FIFO, halt and bus errors
module tb_minimax_dbus_ctrl;
   localparam logic [31:0] CON  = 32'hfffffff8;
   localparam logic [31:0] HALT = 32'hfffffffc;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   minimax_dbus_ctrl_if #(.ADDR_BITS(12)) bus ();
   minimax_dbus_ctrl #(
      .ADDR_BITS(12), .RAM_LATENCY(1), .FIFO_DEPTH(4), .CONSOLE_ADDR(CON), .HALT_ADDR(HALT)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   logic [31:0] mem [1024];
   logic [31:0] ram_q;
   always_ff @(posedge clk) begin
      if (bus.ram_en) begin
         ram_q <= mem[bus.ram_addr];
         for (int b = 0; b < 4; b++)
            if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
   end
   assign bus.ram_rdata = ram_q;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.addr = '0; bus.wdata = '0; bus.wmask = '0; bus.rreq = 1'b0;
      bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0;
      bus.host_wdata = '0; bus.host_wmask = '0; bus.con_ready = 1'b0;
      cyc(); cyc();
      reset = 1'b0;
      #1;
      chk("rst_rack", 32'(bus.rack), 0);
      chk("rst_hrvalid", 32'(bus.host_rvalid), 0);
      chk("rst_ram_en", 32'(bus.ram_en), 0);
      chk("rst_con_valid", 32'(bus.con_valid), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      chk("rst_bus_err", 32'(bus.bus_err), 0);
      // host write then host read of 0x10
      cyc();
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 12'h010;
      bus.host_wdata = 32'h11223344; bus.host_wmask = 4'hf;
      #1;
      chk("t1_wgnt", 32'(bus.host_gnt), 1);
      chk("t1_ram_we", 32'(bus.ram_we), 32'hf);
      chk("t1_ram_addr", 32'(bus.ram_addr), 32'h4);
      cyc();
      bus.host_we = 1'b0;
      #1;
      chk("t1_rgnt", 32'(bus.host_gnt), 1);
      chk("t1_rd_we", 32'(bus.ram_we), 0);
      cyc();
      bus.host_req = 1'b0;
      #1;
      chk("t1_rvalid", 32'(bus.host_rvalid), 1);
      chk("t1_rdata", bus.host_rdata, 32'h11223344);
      // core read collides with host read: core first, host next cycle
      cyc();
      bus.rreq = 1'b1; bus.addr = 32'h10; bus.host_req = 1'b1;
      #1;
      chk("t2_gnt0", 32'(bus.host_gnt), 0);
      chk("t2_ram_en", 32'(bus.ram_en), 1);
      cyc();
      bus.rreq = 1'b0;
      #1;
      chk("t2_rack", 32'(bus.rack), 1);
      chk("t2_rdata", bus.rdata, 32'h11223344);
      chk("t2_gnt1", 32'(bus.host_gnt), 1);
      cyc();
      bus.host_req = 1'b0;
      #1;
      chk("t2_rack_off", 32'(bus.rack), 0);
      chk("t2_hrvalid", 32'(bus.host_rvalid), 1);
      chk("t2_hrdata", bus.host_rdata, 32'h11223344);
      // five console writes into a depth-4 FIFO
      cyc();
      bus.addr = CON; bus.wmask = 4'hf;
      for (int i = 0; i < 5; i++) begin
         bus.wdata = 32'ha0 + 32'(i);
         #1;
         if (i == 0) chk("t3_no_ram_en", 32'(bus.ram_en), 0);
         cyc();
      end
      bus.wmask = 4'h0;
      #1;
      chk("t3_overflow", 32'(bus.overflow), 1);
      chk("t3_con_valid", 32'(bus.con_valid), 1);
      bus.rreq = 1'b1;
      cyc();
      bus.rreq = 1'b0;
      #1;
      chk("t3_status", bus.rdata, 32'h3);
      bus.con_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t3_pop_data", bus.con_data, 32'ha0 + 32'(i));
         cyc();
      end
      bus.con_ready = 1'b0;
      #1;
      chk("t3_empty", 32'(bus.con_valid), 0);
      // full FIFO with simultaneous push and pop
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("t4_ovf_clr", 32'(bus.overflow), 0);
      bus.addr = CON; bus.wmask = 4'hf;
      for (int i = 0; i < 4; i++) begin
         bus.wdata = 32'hb0 + 32'(i);
         cyc();
      end
      bus.wdata = 32'hb4; bus.con_ready = 1'b1;
      cyc();
      bus.wmask = 4'h0; bus.con_ready = 1'b0;
      #1;
      chk("t4_no_ovf", 32'(bus.overflow), 0);
      chk("t4_head", bus.con_data, 32'hb1);
      bus.rreq = 1'b1;
      cyc();
      bus.rreq = 1'b0;
      #1;
      chk("t4_full", bus.rdata, 32'h3);
      bus.con_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t4_pop_data", bus.con_data, 32'hb1 + 32'(i));
         cyc();
      end
      bus.con_ready = 1'b0;
      // halt, then core writes dropped while host keeps working
      bus.addr = HALT; bus.wdata = 32'hffffffff; bus.wmask = 4'hf;
      #1;
      chk("t5_not_yet", 32'(bus.halted), 0);
      cyc();
      bus.wmask = 4'h0;
      #1;
      chk("t5_halted", 32'(bus.halted), 1);
      bus.addr = 32'h20; bus.wdata = 32'hdeadbeef; bus.wmask = 4'hf;
      #1;
      chk("t5_no_ram_en", 32'(bus.ram_en), 0);
      bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'h010;
      #1;
      chk("t5_host_gnt", 32'(bus.host_gnt), 1);
      chk("t5_ram_we", 32'(bus.ram_we), 0);
      cyc();
      bus.host_req = 1'b0; bus.wmask = 4'h0;
      #1;
      chk("t5_hrdata", bus.host_rdata, 32'h11223344);
      bus.addr = HALT; bus.rreq = 1'b1;
      cyc();
      bus.rreq = 1'b0;
      #1;
      chk("t5_halt_rd", bus.rdata, 32'h1);
      // unmapped read, then reset with a read in flight
      bus.addr = 32'h80000000; bus.rreq = 1'b1;
      #1;
      chk("t6_no_ram_en", 32'(bus.ram_en), 0);
      cyc();
      bus.rreq = 1'b0;
      #1;
      chk("t6_rack", 32'(bus.rack), 1);
      chk("t6_rdata", bus.rdata, 32'h0);
      chk("t6_bus_err", 32'(bus.bus_err), 1);
      bus.addr = 32'h10; bus.rreq = 1'b1;
      cyc();
      bus.rreq = 1'b0; reset = 1'b1;
      #1;
      chk("t6_flush_rst", 32'(bus.rack), 0);
      cyc();
      reset = 1'b0;
      #1;
      chk("t6_flush_after", 32'(bus.rack), 0);
      chk("t6_err_clr", 32'(bus.bus_err), 0);
      chk("t6_halt_clr", 32'(bus.halted), 0);
      cyc();
      chk("t6_flush_late", 32'(bus.rack), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
